// File: rtl/seq_sub_pkg.sv
// Shared definitions for the multi-cycle Y86-64 subtractor: FSM state type,
// default geometry and the chunk-counter width helper.
package seq_sub_pkg;

    // Operation phases of the subtractor.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int DEF_WIDTH = 64;
    localparam int DEF_CHUNK = 16;
    localparam int DEF_CNT_W = $clog2(DEF_WIDTH / DEF_CHUNK);

    // Chunk counter width; a single-chunk build still needs a 1-bit counter.
    function automatic int cnt_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple adder with carry-in and carry-out.
// One instance is shared by every chunk of a multi-cycle operation.
module chunk_adder #(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic [CHUNK:0] carry_s;

    assign carry_s[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        full_adder u_fa (
            .a   (a[i]),
            .b   (b[i]),
            .cin (carry_s[i]),
            .sum (sum[i]),
            .cout(carry_s[i+1])
        );
    end

    assign cout = carry_s[CHUNK];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell, the building block of the chunk adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/seq_subtractor.sv
// Multi-cycle WIDTH-bit subtractor (A + ~B + 1), CHUNK bits per cycle with
// the carry registered between chunks. Produces diff, borrow and the Y86
// condition-code inputs zf/sf/of behind a start/ready/done handshake.
// Optional macro SEQ_SUB_ADD_MODE_EN adds an `op` input (1 = add).
// CHUNK must divide WIDTH exactly.
module seq_subtractor
    import seq_sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SEQ_SUB_ADD_MODE_EN
    input  logic             op,
`endif
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zf,
    output logic             sf,
    output logic             of
);

    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = cnt_width(N);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    state_t           state_r, next_state_s;
    logic [CNT_W-1:0] cnt_r;
    logic             carry_r;
    logic [WIDTH-1:0] a_r, nb_r, diff_r, diff_next_s;
    logic [WIDTH-1:0] b_load_s;
    logic             carry_init_s;
    logic             add_mode_s;
    logic [CHUNK-1:0] a_chunk_s, nb_chunk_s, sum_s;
    logic             cout_s;
    logic             accept_s, last_s;
    int               idx_s;
    logic             ready_s, busy_s, done_s;
    logic             ready_r, busy_r, done_r;
    logic             borrow_r, zf_r, sf_r, of_r;

`ifdef SEQ_SUB_ADD_MODE_EN
    logic op_r;
    assign add_mode_s = op_r;
`else
    assign add_mode_s = 1'b0;
`endif

    assign accept_s = start && ((state_r == IDLE) || (state_r == DONE));
    assign last_s   = (cnt_r == LAST_CNT);

    // Operand preparation at the accepting edge: invert b and seed carry for subtract.
    always_comb begin
        b_load_s     = ~b;
        carry_init_s = 1'b1;
`ifdef SEQ_SUB_ADD_MODE_EN
        if (op) begin
            b_load_s     = b;
            carry_init_s = 1'b0;
        end else begin
            b_load_s     = ~b;
            carry_init_s = 1'b1;
        end
`endif
    end

    // Select the current chunk and form the diff as it will look after this edge.
    always_comb begin
        idx_s       = int'(cnt_r) * CHUNK;
        a_chunk_s   = a_r[idx_s +: CHUNK];
        nb_chunk_s  = nb_r[idx_s +: CHUNK];
        diff_next_s = diff_r;
        diff_next_s[idx_s +: CHUNK] = sum_s;
    end

    chunk_adder #(
        .CHUNK(CHUNK)
    ) u_chunk_adder (
        .a   (a_chunk_s),
        .b   (nb_chunk_s),
        .cin (carry_r),
        .sum (sum_s),
        .cout(cout_s)
    );

    // State register; reset abandons any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic: start is only honoured in IDLE and DONE.
    always_comb begin
        next_state_s = IDLE;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s = CALC;
                end else begin
                    next_state_s = IDLE;
                end
            end
            CALC: begin
                if (last_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = CALC;
                end
            end
            DONE: begin
                if (start) begin
                    next_state_s = CALC;
                end else begin
                    next_state_s = IDLE;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Handshake decode from the upcoming state so the outputs can be registered.
    always_comb begin
        ready_s = 1'b0;
        busy_s  = 1'b0;
        done_s  = 1'b0;
        case (next_state_s)
            IDLE: ready_s = 1'b1;
            CALC: busy_s  = 1'b1;
            DONE: begin
                ready_s = 1'b1;
                done_s  = 1'b1;
            end
            default: ready_s = 1'b0;
        endcase
    end

    // Registered handshake outputs; ready is the only one high out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            ready_r <= ready_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    // Datapath: latch operands on accept, then one chunk per CALC edge;
    // flags are taken from the complete diff on the last chunk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r      <= {WIDTH{1'b0}};
            nb_r     <= {WIDTH{1'b0}};
            diff_r   <= {WIDTH{1'b0}};
            carry_r  <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
            borrow_r <= 1'b0;
            zf_r     <= 1'b0;
            sf_r     <= 1'b0;
            of_r     <= 1'b0;
`ifdef SEQ_SUB_ADD_MODE_EN
            op_r     <= 1'b0;
`endif
        end else if (accept_s) begin
            a_r     <= a;
            nb_r    <= b_load_s;
            carry_r <= carry_init_s;
            cnt_r   <= {CNT_W{1'b0}};
`ifdef SEQ_SUB_ADD_MODE_EN
            op_r    <= op;
`endif
        end else if (state_r == CALC) begin
            diff_r  <= diff_next_s;
            carry_r <= cout_s;
            if (last_s) begin
                cnt_r    <= {CNT_W{1'b0}};
                // Subtract reports borrow (no carry out); add reports the raw carry.
                borrow_r <= add_mode_s ? cout_s : ~cout_s;
                zf_r     <= (diff_next_s == {WIDTH{1'b0}});
                sf_r     <= diff_next_s[WIDTH-1];
                // nb_r holds the effective addend, so overflow is "same-sign
                // addends, different-sign result" in both modes.
                of_r     <= (a_r[WIDTH-1] == nb_r[WIDTH-1]) &&
                            (diff_next_s[WIDTH-1] != a_r[WIDTH-1]);
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    assign ready  = ready_r;
    assign busy   = busy_r;
    assign done   = done_r;
    assign diff   = diff_r;
    assign borrow = borrow_r;
    assign zf     = zf_r;
    assign sf     = sf_r;
    assign of     = of_r;

endmodule

// File: tb/tb_seq_subtractor.sv
// Self-checking bench for seq_subtractor: directed corner cases plus
// randomized traffic compared cycle by cycle against an arithmetic model.
module tb_seq_subtractor;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] a, b;
    logic        op_in;
    logic        ready, busy, done;
    logic [63:0] diff;
    logic        borrow, zf, sf, of;

`ifdef SEQ_SUB_ADD_MODE_EN
    logic op;
    assign op_in = op;
`else
    assign op_in = 1'b0;
`endif

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    seq_subtractor dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
`ifdef SEQ_SUB_ADD_MODE_EN
        .op    (op),
`endif
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .borrow(borrow),
        .zf    (zf),
        .sf    (sf),
        .of    (of)
    );

    // Reference result: {of, borrow/carry, diff} from plain wide arithmetic.
    function automatic logic [65:0] ref_op(input logic [63:0] x, input logic [63:0] y, input logic add);
        logic [64:0] w;
        logic        c, o;
        if (add) begin
            w = {1'b0, x} + {1'b0, y};
            c = w[64];
            o = (x[63] == y[63]) && (w[63] != x[63]);
        end else begin
            w = {1'b0, x} - {1'b0, y};
            c = (x < y);
            o = (x[63] != y[63]) && (w[63] != x[63]);
        end
        return {o, c, w[63:0]};
    endfunction

    // Behavioural model: an accepted request yields its result N edges later.
    int          m_left;
    logic        m_done;
    logic [63:0] m_diff;
    logic        m_borrow, m_zf, m_sf, m_of;
    logic [65:0] p_res;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left   <= 0;
            m_done   <= 1'b0;
            m_diff   <= 64'd0;
            m_borrow <= 1'b0;
            m_zf     <= 1'b0;
            m_sf     <= 1'b0;
            m_of     <= 1'b0;
            p_res    <= 66'd0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_done   <= 1'b1;
                m_diff   <= p_res[63:0];
                m_borrow <= p_res[64];
                m_of     <= p_res[65];
                m_zf     <= (p_res[63:0] == 64'd0);
                m_sf     <= p_res[63];
            end else begin
                m_done <= 1'b0;
            end
        end else begin
            m_done <= 1'b0;
            if (start) begin
                m_left <= N;
                p_res  <= ref_op(a, b, op_in);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Per-cycle comparison against the model; results only once they are valid.
    always @(negedge clk) begin
        chk("ready", ready, 64'(m_left == 0));
        chk("busy", busy, 64'(m_left > 0));
        chk("done", done, 64'(m_done));
        if (m_left == 0) begin
            chk("diff", diff, m_diff);
            chk("borrow", borrow, 64'(m_borrow));
            chk("zf", zf, 64'(m_zf));
            chk("sf", sf, 64'(m_sf));
            chk("of", of, 64'(m_of));
        end
        if (done === 1'b1) done_cnt++;
    end

    // Issue one request (call at a falling edge); lat = falling edges until done.
    task automatic issue(input logic [63:0] ia, input logic [63:0] ib, input logic iop,
                         input logic poke, output int lat);
        #1;
        a = ia;
        b = ib;
`ifdef SEQ_SUB_ADD_MODE_EN
        op = iop;
`endif
        start = 1'b1;
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = k;
                break;
            end
            #1;
            if (k == 1) start = 1'b0;
            if (poke && k == 2) begin
                a = ~ia;
                b = ia ^ 64'h5555_5555_5555_5555;
                start = 1'b1;
            end
            if (k == 3) start = 1'b0;
        end
    endtask

    function automatic logic [63:0] pick();
        logic [63:0] v;
        case ($urandom_range(0, 6))
            0: v = 64'd0;
            1: v = 64'hFFFF_FFFF_FFFF_FFFF;
            2: v = 64'h8000_0000_0000_0000;
            3: v = 64'h7FFF_FFFF_FFFF_FFFF;
            4: v = 64'd1;
            default: v = {$urandom(), $urandom()};
        endcase
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int dc;
        rst = 1'b1;
        start = 1'b0;
        a = 64'd0;
        b = 64'd0;
`ifdef SEQ_SUB_ADD_MODE_EN
        op = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst ready", ready, 64'd1);
        chk("rst busy", busy, 64'd0);
        chk("rst done", done, 64'd0);
        chk("rst diff", diff, 64'd0);
        #1 rst = 1'b0;
        @(negedge clk);

        issue(64'd10, 64'd3, 1'b0, 1'b0, lat);
        chk("t1 latency", 64'(lat), 64'd5);
        chk("t1 diff", diff, 64'd7);
        chk("t1 model", m_diff, 64'd7);
        chk("t1 flags", {borrow, zf, sf, of}, 64'd0);

        @(negedge clk);
        issue(64'd0, 64'd1, 1'b0, 1'b0, lat);
        chk("t2 diff", diff, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t2 flags b/z/s/o", {borrow, zf, sf, of}, 64'b1010);
        chk("t2 model borrow", 64'(m_borrow), 64'd1);

        @(negedge clk);
        issue(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b0, lat);
        chk("t3 diff", diff, 64'h7FFF_FFFF_FFFF_FFFF);
        chk("t3 flags b/z/s/o", {borrow, zf, sf, of}, 64'b0001);
        chk("t3 model of", 64'(m_of), 64'd1);

        @(negedge clk);
        issue(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0, lat);
        chk("t4 diff", diff, 64'd0);
        chk("t4 zf", 64'(zf), 64'd1);
        chk("t4 borrow", 64'(borrow), 64'd0);
        // Back-to-back: start in the DONE cycle.
        issue(64'd5, 64'd7, 1'b0, 1'b0, lat);
        chk("b2b latency", 64'(lat), 64'd5);
        chk("b2b diff", diff, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("b2b borrow", 64'(borrow), 64'd1);

        @(negedge clk);
        issue(64'd100, 64'd40, 1'b0, 1'b1, lat);
        chk("poke latency", 64'(lat), 64'd5);
        chk("poke diff", diff, 64'd60);

        // Reset two edges into an operation: ready at once, no done afterwards.
        @(negedge clk);
        #1;
        a = 64'd9;
        b = 64'd4;
        start = 1'b1;
        @(negedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort ready", ready, 64'd1);
        chk("abort busy", busy, 64'd0);
        chk("abort diff", diff, 64'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        dc = done_cnt;
        repeat (8) @(negedge clk);
        chk("abort no done", 64'(done_cnt - dc), 64'd0);

`ifdef SEQ_SUB_ADD_MODE_EN
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 1'b0, lat);
        chk("add diff", diff, 64'd0);
        chk("add flags b/z/s/o", {borrow, zf, sf, of}, 64'b1100);
        @(negedge clk);
`endif

        // Randomized traffic, including starts during CALC and rare resets.
        dc = done_cnt;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            #1;
            rst = ($urandom_range(0, 499) == 0);
            start = ($urandom_range(0, 3) == 0);
            a = pick();
            b = pick();
`ifdef SEQ_SUB_ADD_MODE_EN
            op = 1'($urandom_range(0, 1));
`endif
        end
        #1;
        rst = 1'b0;
        start = 1'b0;
        repeat (8) @(negedge clk);
        chk("random dones seen", 64'(done_cnt - dc > 100), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
